// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Bundles the request/response signals of the bit-serial adder.
//
//   start  master->slave  begin an addition (only looked at while idle)
//   a, b   master->slave  WIDTH-bit operands, captured on the accepting edge
//   cin    master->slave  carry-in, captured on the accepting edge
//   busy   slave->master  bits are being processed
//   done   slave->master  one-cycle pulse when sum/cout have been updated
//   sum    slave->master  registered WIDTH-bit result
//   cout   slave->master  registered carry out of the MSB
//   ovf    slave->master  registered signed overflow (SERIAL_ADDER_OVF_EN only)
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf signal.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial ripple adder: adds two WIDTH-bit operands plus a carry-in one bit
// per clock, LSB first, through a single 1-bit full-adder cell whose carry-out
// is fed back through a carry flip-flop. Area-minimal alternative to a
// WIDTH-wide ripple adder.
//
// Parameters
//   WIDTH  operand/result width, 2..32 (default 8)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_if.slave: start/a/b/cin in, busy/done/sum/cout(/ovf) out
//
// Timing: start accepted at edge E0, busy high after E0 through E(WIDTH),
// final bit processed at E(WIDTH) (sum/cout updated, done=1), done drops and
// the block is idle again after E(WIDTH+1). One addition per WIDTH+2 cycles.
//
// Build option: SERIAL_ADDER_OVF_EN adds the registered signed-overflow output
// ovf = (carry into MSB) ^ (carry out of MSB).
// -----------------------------------------------------------------------------

// 1-bit full-adder cell.
module serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;        // operand A shift register
    logic [WIDTH-1:0] b_q, b_d;        // operand B shift register
    logic [WIDTH-1:0] res_q, res_d;    // result shift register (fills from MSB)
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_co;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    serial_adder_fa u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {fa_s, res_q[WIDTH-1:1]};

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                res_d   = res_next;
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d   = res_next;
                    cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // While the MSB is being added the carry FF holds the carry
                    // into the MSB, so it doubles as the carry-into-MSB term.
                    ovf_d   = carry_q ^ fa_co;
`endif
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: pure registered decodes, no path from start.
    // -------------------------------------------------------------------------
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
